run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_if.sv | 27 ++
 rtl/run_ctrl.sv | 98 +++++++++
 tb/tb_run_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_if.sv
// Host/decoder/program-counter signal bundle for run_ctrl.
// The master drives the host and decoder requests; the slave (run_ctrl) drives the PC controls and status.
interface run_ctrl_if;
    logic        Start;
    logic [1:0]  ProgSel;
    logic        DecBranchAbs;
    logic        DecBranchRel;
    logic        DecHalt;
    logic [9:0]  DecTarget;
    logic        PcHold;
    logic        BranchAbsEn;
    logic        BranchRelEn;
    logic [9:0]  Target;
    logic        Running;
    logic        Done;
    logic [15:0] CycleCount;

    modport master (
        output Start, ProgSel, DecBranchAbs, DecBranchRel, DecHalt, DecTarget,
        input  PcHold, BranchAbsEn, BranchRelEn, Target, Running, Done, CycleCount
    );

    modport slave (
        input  Start, ProgSel, DecBranchAbs, DecBranchRel, DecHalt, DecTarget,
        output PcHold, BranchAbsEn, BranchRelEn, Target, Running, Done, CycleCount
    );
endinterface

// File: rtl/run_ctrl.sv
// Program run controller: IDLE -> ARMED -> LOAD -> RUN -> DONE, steering the program counter.
// Optional RUN cycle counter enabled by defining RUN_CTRL_CYCLE_COUNT_EN.
module run_ctrl (
    input logic       Clk,
    input logic       Reset,
    run_ctrl_if.slave ctrlBus
);
    typedef enum logic [2:0] {IDLE, ARMED, LOAD, RUN, DONE} state_t;

    state_t     state;
    state_t     nextState;
    logic [1:0] progSelLatched;
    logic       pcHold;
    logic       branchAbsEn;
    logic       branchRelEn;
    logic [9:0] target;
    logic       armedRelease;

    // Start falling edge as seen from ARMED: latch the program and enter LOAD
    assign armedRelease = (state == ARMED) && !ctrlBus.Start;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            progSelLatched <= '0;
        end else begin
            state <= nextState;
            if (armedRelease)
                progSelLatched <= ctrlBus.ProgSel;
        end
    end

    always_comb begin
        nextState   = state;
        pcHold      = 1'b1;
        branchAbsEn = 1'b0;
        branchRelEn = 1'b0;
        target      = '0;
        case (state)
            IDLE: begin
                if (ctrlBus.Start)
                    nextState = ARMED;
            end
            ARMED: begin
                if (!ctrlBus.Start)
                    nextState = LOAD;
            end
            LOAD: begin
                pcHold      = 1'b0;
                branchAbsEn = 1'b1;
                target      = {progSelLatched, 8'h00};
                nextState   = RUN;
            end
            RUN: begin
                target = ctrlBus.DecTarget;
                // Abort beats halt, halt beats branches; both freeze the PC
                if (ctrlBus.Start) begin
                    nextState = ARMED;
                end else if (ctrlBus.DecHalt) begin
                    nextState = DONE;
                end else begin
                    pcHold      = 1'b0;
                    branchAbsEn = ctrlBus.DecBranchAbs;
                    branchRelEn = ctrlBus.DecBranchRel && !ctrlBus.DecBranchAbs;
                end
            end
            DONE: begin
                if (ctrlBus.Start)
                    nextState = ARMED;
            end
            default: nextState = IDLE;
        endcase
    end

    assign ctrlBus.PcHold      = pcHold;
    assign ctrlBus.BranchAbsEn = branchAbsEn;
    assign ctrlBus.BranchRelEn = branchRelEn;
    assign ctrlBus.Target      = target;
    assign ctrlBus.Running     = (state == RUN);
    assign ctrlBus.Done        = (state == DONE);

`ifdef RUN_CTRL_CYCLE_COUNT_EN
    logic [15:0] cycleCount;

    always_ff @(posedge Clk) begin
        if (Reset)
            cycleCount <= '0;
        else if (armedRelease)
            cycleCount <= '0;
        else if (state == RUN && cycleCount != '1)
            cycleCount <= cycleCount + 16'd1;
    end

    assign ctrlBus.CycleCount = cycleCount;
`else
    assign ctrlBus.CycleCount = '0;
`endif
endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_run_ctrl;
    logic Clk;
    logic Reset;

    run_ctrl_if bus ();

    run_ctrl dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .ctrlBus (bus.slave)
    );

`ifdef RUN_CTRL_CYCLE_COUNT_EN
    localparam bit CountEn = 1'b1;
`else
    localparam bit CountEn = 1'b0;
`endif

    // mask bits: 0 PcHold, 1 BranchAbsEn, 2 BranchRelEn, 3 Target, 4 Running, 5 Done, 6 CycleCount
    localparam logic [6:0] MaskAll   = 7'h7F;
    localparam logic [6:0] MaskNoTgt = 7'h77;
    localparam logic [6:0] MaskState = 7'h70;

    typedef struct {
        string       name;
        logic [6:0]  mask;
        logic        ph;
        logic        ab;
        logic        rl;
        logic [9:0]  tg;
        logic        rn;
        logic        dn;
        logic [15:0] cc;
    } exp_t;

    exp_t q[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic bad;
            e = q.pop_front();
            bad = 1'b0;
            if (e.mask[0] && bus.PcHold      !== e.ph) bad = 1'b1;
            if (e.mask[1] && bus.BranchAbsEn !== e.ab) bad = 1'b1;
            if (e.mask[2] && bus.BranchRelEn !== e.rl) bad = 1'b1;
            if (e.mask[3] && bus.Target      !== e.tg) bad = 1'b1;
            if (e.mask[4] && bus.Running     !== e.rn) bad = 1'b1;
            if (e.mask[5] && bus.Done        !== e.dn) bad = 1'b1;
            if (e.mask[6] && bus.CycleCount  !== e.cc) bad = 1'b1;
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL %s (mask %b): got ph=%b ab=%b rl=%b tg=%0d rn=%b dn=%b cc=%0d, want ph=%b ab=%b rl=%b tg=%0d rn=%b dn=%b cc=%0d",
                         e.name, e.mask, bus.PcHold, bus.BranchAbsEn, bus.BranchRelEn, bus.Target,
                         bus.Running, bus.Done, bus.CycleCount,
                         e.ph, e.ab, e.rl, e.tg, e.rn, e.dn, e.cc);
            end
        end
    end

    task automatic drive(input logic rst, input logic st, input logic [1:0] sel,
                         input logic ba, input logic br, input logic hl, input logic [9:0] tg);
        @(posedge Clk);
        #1;
        Reset            = rst;
        bus.Start        = st;
        bus.ProgSel      = sel;
        bus.DecBranchAbs = ba;
        bus.DecBranchRel = br;
        bus.DecHalt      = hl;
        bus.DecTarget    = tg;
    endtask

    task automatic expect_out(input string n, input logic [6:0] m, input logic ph, input logic ab,
                              input logic rl, input logic [9:0] tg, input logic rn, input logic dn,
                              input int unsigned cnt);
        exp_t e;
        e.name = n; e.mask = m; e.ph = ph; e.ab = ab; e.rl = rl; e.tg = tg;
        e.rn = rn; e.dn = dn;
        e.cc = CountEn ? 16'(cnt) : 16'd0;
        q.push_back(e);
    endtask

    initial begin
        Reset = 1'b1;
        bus.Start = 1'b0; bus.ProgSel = 2'd0;
        bus.DecBranchAbs = 1'b0; bus.DecBranchRel = 1'b0; bus.DecHalt = 1'b0; bus.DecTarget = '0;

        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 1, 1, 10'd55);
        expect_out("reset_state", MaskAll, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 1, 0, 10'd99);
        expect_out("idle_ignores_dec", MaskAll, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 3, 0, 0, 0, 0);
        expect_out("armed", MaskAll, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 2, 1, 0, 0, 10'd20);
        expect_out("armed_hold", MaskAll, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 10'd77);
        expect_out("load_prog2", MaskAll, 0, 1, 0, 10'd512, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("run_quiet", MaskAll, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 10'd10);
        expect_out("both_branches", MaskAll, 0, 1, 0, 10'd10, 1, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 10'd1023);
        expect_out("rel_branch", MaskAll, 0, 0, 1, 10'd1023, 1, 0, 2);
        drive(0, 0, 0, 1, 0, 0, 10'd300);
        expect_out("abs_branch", MaskAll, 0, 1, 0, 10'd300, 1, 0, 3);
        drive(0, 0, 0, 0, 1, 1, 10'd5);
        expect_out("halt_over_rel", MaskNoTgt, 1, 0, 0, 0, 1, 0, 4);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("done", MaskAll, 1, 0, 0, 0, 0, 1, 5);
        drive(0, 0, 0, 1, 1, 0, 10'd9);
        expect_out("done_ignores_dec", MaskAll, 1, 0, 0, 0, 0, 1, 5);
        drive(0, 1, 0, 0, 0, 0, 0);
        expect_out("done_start_seen", MaskAll, 1, 0, 0, 0, 0, 1, 5);
        drive(0, 0, 1, 0, 0, 0, 0);
        expect_out("rearmed_holds_count", MaskAll, 1, 0, 0, 0, 0, 0, 5);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("load_prog1", MaskAll, 0, 1, 0, 10'd256, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 0);
        expect_out("abort_cycle", MaskState, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        expect_out("abort_to_armed", MaskAll, 1, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("reload_prog1", MaskAll, 0, 1, 0, 10'd256, 0, 0, 0);

        for (int unsigned i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            expect_out("run_count", MaskAll, 0, 0, 0, 0, 1, 0, i);
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        expect_out("halt_7th", MaskNoTgt, 1, 0, 0, 0, 1, 0, 6);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("done_count7", MaskAll, 1, 0, 0, 0, 0, 1, 7);

        drive(0, 1, 0, 0, 0, 0, 0);
        expect_out("done_before_restart", MaskAll, 1, 0, 0, 0, 0, 1, 7);
        drive(0, 0, 3, 0, 0, 0, 0);
        expect_out("armed_prog3", MaskAll, 1, 0, 0, 0, 0, 0, 7);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("load_prog3", MaskAll, 0, 1, 0, 10'd768, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0, 10'd4);
        expect_out("run_with_reset", MaskAll, 0, 1, 0, 10'd4, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("reset_from_run", MaskAll, 1, 0, 0, 0, 0, 0, 0);

        drive(0, 1, 0, 0, 0, 0, 0);
        expect_out("idle_again", MaskAll, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 2, 0, 0, 0, 0);
        expect_out("armed_again", MaskAll, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 1, 1, 10'd3);
        expect_out("load_with_reset", MaskAll, 0, 1, 0, 10'd512, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("reset_from_load", MaskAll, 1, 0, 0, 0, 0, 0, 0);

        @(negedge Clk);
        @(negedge Clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
